// File: rtl/sel_result_accum.sv
// sel_result_accum
// Collects windows of N = 2**LOG2_N signed 9-bit samples from the upstream
// selector/adder stage. When a window is full it presents the sum, the average,
// the maximum and the minimum, and holds them until the consumer takes them.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous window abort/flush; it overrides everything else
//   in_valid   in_data carries a sample this cycle
//   in_data    signed 9-bit sample
//   in_ready   a sample can be accepted (IDLE/ACC)
//   out_valid  a window result is presented (HOLD)
//   out_ready  the consumer accepts the presented result
//   out_sum    signed 15-bit sum of the window
//   out_avg    out_sum >>> LOG2_N (floor), 9 bits
//   out_max    signed maximum of the window
//   out_min    signed minimum of the window
//   dbg_state  current FSM state (0 IDLE, 1 ACC, 2 HOLD)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. in_ready and out_valid depend only on the state, so neither one depends
// combinationally on the other side of its handshake.
module sel_result_accum #(
    parameter int LOG2_N = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    input  logic signed [8:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [14:0] out_sum,
    output logic signed [8:0]  out_avg,
    output logic signed [8:0]  out_max,
    output logic signed [8:0]  out_min,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [LOG2_N-1:0]  count;
    logic signed [14:0] acc_sum;
    logic signed [8:0]  acc_max;
    logic signed [8:0]  acc_min;
    logic signed [14:0] in_ext;
    logic signed [14:0] sum_nxt;
    logic signed [8:0]  max_nxt;
    logic signed [8:0]  min_nxt;
    logic               accept;
    logic               last_sample;

    // Handshake and the values this sample produces
    always_comb begin
        in_ready    = (state != HOLD);
        out_valid   = (state == HOLD);
        accept      = in_valid && in_ready;
        // count holds the number of samples already taken, so all-ones means
        // the sample now being accepted completes the window.
        last_sample = (state == ACC) && (count == '1);
        in_ext      = {{6{in_data[8]}}, in_data};
        if (state == IDLE) begin
            sum_nxt = in_ext;
            max_nxt = in_data;
            min_nxt = in_data;
        end else begin
            sum_nxt = acc_sum + in_ext;
            max_nxt = (in_data > acc_max) ? in_data : acc_max;
            min_nxt = (in_data < acc_min) ? in_data : acc_min;
        end
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = ACC;
            ACC:  if (accept && last_sample) state_nxt = HOLD;
            HOLD: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Accumulators and result registers. The results are loaded only when a
    // window completes, so they keep their values after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            acc_sum <= '0;
            acc_max <= '0;
            acc_min <= '0;
            out_sum <= '0;
            out_max <= '0;
            out_min <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (accept) begin
            acc_sum <= sum_nxt;
            acc_max <= max_nxt;
            acc_min <= min_nxt;
            if (last_sample) begin
                count   <= '0;
                out_sum <= sum_nxt;
                out_max <= max_nxt;
                out_min <= min_nxt;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // The shift is done at 15 bits and then truncated. The window average always
    // fits in 9 bits.
    assign out_avg   = 9'(out_sum >>> LOG2_N);
    assign dbg_state = state;

endmodule
